gc_dram_array: RTL and testbench
================================

Name: gc_dram_array

Overview:
- Parametrised behavioural model of a gain-cell DRAM array, single-clocked. Each row loses its data after a fixed retention time unless it is rewritten or refreshed.
- Has a dedicated refresh port, so the refresh controller does not have to use the write port.
- Each row has a state machine: EMPTY, VALID or EXPIRED. Reads report validity and are never X. A sticky error flag records data loss.
- Sits under the DRAM controller / refresh scheduler and replaces the fixed 128x64 array model.

Parameters:
- WIDTH, 64, data bits per row.
- DEPTH, 128, number of rows (≥2).
- RETENTION_CYCLES, 5000, clock edges a row stays readable after its last write or refresh (≥1).
- AW, $clog2(DEPTH), address width (derived; do not override).
- CW, $clog2(RETENTION_CYCLES+1), retention counter width (derived).

Ports:
- clk  in  1  clock; all state changes on posedge only.
- rst  in  1  asynchronous active-high reset.
- we  in  1  write enable.
- waddr  in  AW  write row.
- in  in  WIDTH  write data.
- re  in  1  read enable.
- raddr  in  AW  read row.
- rd  out  WIDTH  registered read data.
- rd_valid  out  1  registered; 1 = rd holds live data.
- ref_en  in  1  refresh strobe.
- ref_addr  in  AW  row to refresh.
- ref_err  out  1  one-cycle pulse: refresh hit a non-VALID row.
- clr_err  in  1  clears decay_err.
- decay_err  out  1  sticky; a VALID row expired.
- live_rows  out  $clog2(DEPTH+1)  count of VALID rows after the current edge.

Behaviour:
- Reset (async assert):
  - All rows go to EMPTY and all counters to 0.
  - rd=0, rd_valid=0, ref_err=0, decay_err=0, live_rows=0.
  - Memory contents are don't-care.
  - Takes effect immediately, including in the middle of an operation; there is no partial completion.
- Per-row state machine, evaluated every posedge in priority order:
  1. Write to the row: store in, counter<=RETENTION_CYCLES, state<=VALID. Allowed from any state.
  2. Else refresh of a VALID row: counter<=RETENTION_CYCLES. Data is unchanged.
  3. Else if VALID and counter>1: counter decrements.
  4. Else if VALID and counter==1: counter<=0, state<=EXPIRED, decay_err<=1.
  5. EMPTY and EXPIRED rows hold their state.
- Retention window: a write at edge N gives valid reads at edges N+1 through N+RETENTION_CYCLES. A read at N+RETENTION_CYCLES+1 returns invalid.
- Refresh on the expiring edge (counter==1) succeeds, because the row was VALID before the edge.
- Refresh of an EMPTY or EXPIRED row:
  - No state change.
  - ref_err=1 for exactly the next cycle.
  - Refresh can never revive a row.
- Write and refresh to the same row on the same edge: the write wins and ref_err stays 0.
- Write and refresh to different rows on the same edge: both take effect.
- Read path, latency 1:
  - At the edge, sample the pre-edge state of raddr.
  - If re=1 and the row is VALID: rd<=mem[raddr], rd_valid<=1.
  - Otherwise: rd<=0, rd_valid<=0.
  - Read and write to the same address on the same edge returns the old contents and old validity (read-before-write).
- decay_err:
  - Set by any row expiry.
  - clr_err=1 clears it unless an expiry happens on the same edge; set wins.
- live_rows is registered and equals the number of VALID rows after the edge; its range is 0..DEPTH.
- The model never drives X on its outputs.

Test Plan:
1. RETENTION_CYCLES=8, DEPTH=16, WIDTH=32.
   - Write row 3 with 0xA5A5_0001 at edge 0.
   - Read row 3 at edges 1 and 8: rd=0xA5A5_0001, rd_valid=1.
   - Read at edge 9: rd=0, rd_valid=0.
   - decay_err=1 from edge 8 on; live_rows goes 1→0 at edge 8.
2. Write row 5 at edge 0, then refresh it at edges 8, 16 and 24.
   - Reads at edges 30 and 32 return the data with rd_valid=1.
   - decay_err stays 0.
   - The row expires at edge 32, so a read at edge 33 returns rd_valid=0.
3. Refresh row 7 while it is EMPTY: ref_err pulses for one cycle and live_rows stays 0. Let row 2 expire, then refresh it: ref_err pulses and a read returns rd_valid=0.
4. Same-edge conflicts:
   - Row 4 holds 0x11. Read and write 0x22 to row 4 on one edge: rd=0x11.
   - The next read returns 0x22.
   - Write and refresh to row 4 on one edge: ref_err=0 and the counter reloads.
5. clr_err and expiry on the same edge: decay_err stays 1. A lone clr_err on a later edge: decay_err=0.
6. Write rows 0–9, then assert rst asynchronously between edges:
   - rd_valid, live_rows and decay_err drop to 0 immediately.
   - After release, reads of rows 0–9 return rd_valid=0.

Source files
------------

// File: rtl/gc_dram_array.sv
// Gain-cell DRAM array model: rows lose their data RETENTION_CYCLES edges after the last
// write or refresh. Each row tracks EMPTY/VALID/EXPIRED plus a retention down-counter.
module gc_dram_array #(
    parameter int unsigned WIDTH            = 64,
    parameter int unsigned DEPTH            = 128,
    parameter int unsigned RETENTION_CYCLES = 5000,
    parameter int unsigned AW               = $clog2(DEPTH),
    parameter int unsigned CW               = $clog2(RETENTION_CYCLES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic [WIDTH-1:0]           in,
    input  logic                       re,
    input  logic [AW-1:0]              raddr,
    output logic [WIDTH-1:0]           rd,
    output logic                       rd_valid,
    input  logic                       ref_en,
    input  logic [AW-1:0]              ref_addr,
    output logic                       ref_err,
    input  logic                       clr_err,
    output logic                       decay_err,
    output logic [$clog2(DEPTH+1)-1:0] live_rows
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] RetLoad = CW'(RETENTION_CYCLES);

    typedef enum logic [1:0] {StEmpty, StValid, StExpired} row_state_e;

    row_state_e       state_q [DEPTH];
    row_state_e       state_d [DEPTH];
    logic [CW-1:0]    cnt_q   [DEPTH];
    logic [CW-1:0]    cnt_d   [DEPTH];
    logic [WIDTH-1:0] mem_q   [DEPTH];

    logic [WIDTH-1:0] rd_q, rd_d;
    logic             rd_valid_q, rd_valid_d;
    logic             ref_err_q, ref_err_d;
    logic             decay_err_q, decay_err_d;
    logic [LW-1:0]    live_rows_q, live_rows_d;
    logic             expire;
    logic             wr_in_range, rd_hit_valid, ref_hit_valid;

    assign wr_in_range   = 32'(waddr) < DEPTH;
    assign rd_hit_valid  = (32'(raddr) < DEPTH) && (state_q[raddr] == StValid);
    assign ref_hit_valid = (32'(ref_addr) < DEPTH) && (state_q[ref_addr] == StValid);

    // Per-row next state; write beats refresh beats decay.
    always_comb begin
        expire      = 1'b0;
        live_rows_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (we && waddr == AW'(i)) begin
                state_d[i] = StValid;
                cnt_d[i]   = RetLoad;
            end else if (ref_en && ref_addr == AW'(i) && state_q[i] == StValid) begin
                cnt_d[i] = RetLoad;
            end else if (state_q[i] == StValid && cnt_q[i] > CW'(1)) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end else if (state_q[i] == StValid) begin
                cnt_d[i]   = '0;
                state_d[i] = StExpired;
                expire     = 1'b1;
            end
            if (state_d[i] == StValid) begin
                live_rows_d = live_rows_d + LW'(1);
            end
        end
    end

    always_comb begin
        rd_d       = '0;
        rd_valid_d = 1'b0;
        if (re && rd_hit_valid) begin
            rd_d       = mem_q[raddr];
            rd_valid_d = 1'b1;
        end
        ref_err_d   = ref_en && !(we && waddr == ref_addr) && !ref_hit_valid;
        decay_err_d = expire | (decay_err_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= StEmpty;
                cnt_q[i]   <= '0;
            end
            rd_q        <= '0;
            rd_valid_q  <= 1'b0;
            ref_err_q   <= 1'b0;
            decay_err_q <= 1'b0;
            live_rows_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            rd_q        <= rd_d;
            rd_valid_q  <= rd_valid_d;
            ref_err_q   <= ref_err_d;
            decay_err_q <= decay_err_d;
            live_rows_q <= live_rows_d;
        end
    end

    // Storage is never read unless its row is VALID, so it needs no reset.
    always_ff @(posedge clk) begin
        if (we && wr_in_range) begin
            mem_q[waddr] <= in;
        end
    end

    assign rd        = rd_q;
    assign rd_valid  = rd_valid_q;
    assign ref_err   = ref_err_q;
    assign decay_err = decay_err_q;
    assign live_rows = live_rows_q;

endmodule

// File: tb/tb_gc_dram_array.sv
// Bench for gc_dram_array: directed scenarios with literal expectations plus random traffic,
// all compared each cycle against a timestamp-based retention model.
module tb_gc_dram_array;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int RET   = 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             we = 1'b0, re = 1'b0, ref_en = 1'b0, clr_err = 1'b0;
    logic [AW-1:0]    waddr = '0, raddr = '0, ref_addr = '0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] rd;
    logic             rd_valid, ref_err, decay_err;
    logic [LW-1:0]    live_rows;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    gc_dram_array #(
        .WIDTH            (WIDTH),
        .DEPTH            (DEPTH),
        .RETENTION_CYCLES (RET)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .in        (din),
        .re        (re),
        .raddr     (raddr),
        .rd        (rd),
        .rd_valid  (rd_valid),
        .ref_en    (ref_en),
        .ref_addr  (ref_addr),
        .ref_err   (ref_err),
        .clr_err   (clr_err),
        .decay_err (decay_err),
        .live_rows (live_rows)
    );

    always #5 clk = ~clk;

    // Model: a row is readable at edge e iff it was written and e - last_touch <= RET.
    longint           m_e;
    bit               m_written [DEPTH];
    longint           m_t       [DEPTH];
    logic [WIDTH-1:0] m_data    [DEPTH];
    bit               m_pv      [DEPTH];
    logic [WIDTH-1:0] exp_rd;
    bit               exp_rv, exp_ref_err, exp_decay;
    int               exp_live;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_e = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_written[i] = 1'b0;
            m_t[i]       = 0;
        end
        exp_rd = '0; exp_rv = 1'b0; exp_ref_err = 1'b0; exp_decay = 1'b0; exp_live = 0;
    endtask

    task automatic model_step();
        bit expired;
        bit ref_ok;
        expired = 1'b0;
        m_e++;
        for (int i = 0; i < DEPTH; i++) begin
            m_pv[i] = m_written[i] && (m_e - m_t[i] <= RET);
        end
        ref_ok      = ref_en && !(we && waddr == ref_addr);
        exp_ref_err = ref_ok && !m_pv[ref_addr];
        exp_rv      = re && m_pv[raddr];
        exp_rd      = exp_rv ? m_data[raddr] : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_pv[i] && (m_e - m_t[i] == RET) && !(we && int'(waddr) == i)
                && !(ref_en && int'(ref_addr) == i)) begin
                expired = 1'b1;
            end
        end
        if (we) begin
            m_written[waddr] = 1'b1;
            m_t[waddr]       = m_e;
            m_data[waddr]    = din;
        end
        if (ref_ok && m_pv[ref_addr]) m_t[ref_addr] = m_e;
        exp_decay = expired | (exp_decay & ~clr_err);
        exp_live  = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_written[i] && (m_e - m_t[i] < RET)) exp_live++;
        end
    endtask

    always @(posedge clk) begin
        if (chk_en && !rst) begin
            model_step();
            #1;
            if (!rst) begin
                check("rd", 64'(rd), 64'(exp_rd));
                check("rd_valid", 64'(rd_valid), 64'(exp_rv));
                check("ref_err", 64'(ref_err), 64'(exp_ref_err));
                check("decay_err", 64'(decay_err), 64'(exp_decay));
                check("live_rows", 64'(live_rows), 64'(exp_live));
            end
        end
    end

    task automatic tick(input bit w, input int wa, input logic [WIDTH-1:0] d, input bit r,
                        input int ra, input bit f, input int fa, input bit c);
        @(negedge clk);
        we = w; waddr = AW'(wa); din = d; re = r; raddr = AW'(ra);
        ref_en = f; ref_addr = AW'(fa); clr_err = c;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_live", 64'(live_rows), 64'd0);
        check("rst_decay", 64'(decay_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: retention window of a single write
        tick(1, 3, 32'hA5A5_0001, 0, 0, 0, 0, 0);
        tick(0, 0, '0, 1, 3, 0, 0, 0);
        check("t1_rd_e1", 64'(rd), 64'hA5A5_0001);
        check("t1_rv_e1", 64'(rd_valid), 64'd1);
        check("t1_live_e1", 64'(live_rows), 64'd1);
        idle(6);
        check("t1_live_e7", 64'(live_rows), 64'd1);
        check("t1_decay_e7", 64'(decay_err), 64'd0);
        tick(0, 0, '0, 1, 3, 0, 0, 0);
        check("t1_rd_e8", 64'(rd), 64'hA5A5_0001);
        check("t1_rv_e8", 64'(rd_valid), 64'd1);
        check("t1_decay_e8", 64'(decay_err), 64'd1);
        check("t1_live_e8", 64'(live_rows), 64'd0);
        tick(0, 0, '0, 1, 3, 0, 0, 0);
        check("t1_rd_e9", 64'(rd), 64'd0);
        check("t1_rv_e9", 64'(rd_valid), 64'd0);

        // 2: periodic refresh keeps a row alive
        tick(0, 0, '0, 0, 0, 0, 0, 1);
        check("t2_clr", 64'(decay_err), 64'd0);
        for (int e = 0; e <= 33; e++) begin
            tick(e == 0, 5, 32'h5555_0005, (e == 30 || e == 32 || e == 33), 5,
                 (e == 8 || e == 16 || e == 24), 5, 0);
            if (e == 24) check("t2_referr_e24", 64'(ref_err), 64'd0);
            if (e == 30 || e == 32) begin
                check("t2_rd", 64'(rd), 64'h5555_0005);
                check("t2_rv", 64'(rd_valid), 64'd1);
            end
            if (e == 31) check("t2_decay_e31", 64'(decay_err), 64'd0);
            if (e == 33) begin
                check("t2_rv_e33", 64'(rd_valid), 64'd0);
                check("t2_decay_e33", 64'(decay_err), 64'd1);
            end
        end

        // 3: refresh of EMPTY / EXPIRED rows
        tick(0, 0, '0, 0, 0, 1, 7, 0);
        check("t3_referr_empty", 64'(ref_err), 64'd1);
        check("t3_live", 64'(live_rows), 64'd0);
        idle(1);
        check("t3_referr_pulse", 64'(ref_err), 64'd0);
        tick(1, 2, 32'h0000_0002, 0, 0, 0, 0, 0);
        idle(8);
        tick(0, 0, '0, 0, 0, 1, 2, 0);
        check("t3_referr_expired", 64'(ref_err), 64'd1);
        tick(0, 0, '0, 1, 2, 0, 0, 0);
        check("t3_rv_expired", 64'(rd_valid), 64'd0);

        // 4: same-edge conflicts
        tick(1, 4, 32'h11, 0, 0, 0, 0, 0);
        tick(1, 4, 32'h22, 1, 4, 0, 0, 0);
        check("t4_rbw_rd", 64'(rd), 64'h11);
        check("t4_rbw_rv", 64'(rd_valid), 64'd1);
        tick(0, 0, '0, 1, 4, 0, 0, 0);
        check("t4_new_rd", 64'(rd), 64'h22);
        tick(1, 4, 32'h33, 0, 0, 1, 4, 0);
        check("t4_wr_ref_err", 64'(ref_err), 64'd0);
        idle(7);
        tick(0, 0, '0, 1, 4, 0, 0, 0);
        check("t4_reload_rd", 64'(rd), 64'h33);
        check("t4_reload_rv", 64'(rd_valid), 64'd1);
        tick(0, 0, '0, 1, 4, 0, 0, 0);
        check("t4_reload_end", 64'(rd_valid), 64'd0);

        // 5: expiry beats clr_err on the same edge
        tick(0, 0, '0, 0, 0, 0, 0, 1);
        check("t5_clr0", 64'(decay_err), 64'd0);
        tick(1, 6, 32'h66, 0, 0, 0, 0, 0);
        idle(7);
        tick(0, 0, '0, 0, 0, 0, 0, 1);
        check("t5_set_wins", 64'(decay_err), 64'd1);
        tick(0, 0, '0, 0, 0, 0, 0, 1);
        check("t5_clr", 64'(decay_err), 64'd0);

        // 6: asynchronous reset mid-cycle
        tick(1, 11, 32'hBB, 0, 0, 0, 0, 0);
        for (int r = 0; r < 10; r++) tick(1, r, 32'h6000_0000 + r, 0, 0, 0, 0, 0);
        tick(0, 0, '0, 1, 9, 0, 0, 0);
        check("t6_pre_rv", 64'(rd_valid), 64'd1);
        check("t6_pre_rd", 64'(rd), 64'h6000_0009);
        check("t6_pre_decay", 64'(decay_err), 64'd1);
        check("t6_pre_live", 64'(live_rows), 64'd7);
        #1;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_rv", 64'(rd_valid), 64'd0);
        check("t6_rst_live", 64'(live_rows), 64'd0);
        check("t6_rst_decay", 64'(decay_err), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        for (int r = 0; r < 10; r++) begin
            tick(0, 0, '0, 1, r, 0, 0, 0);
            check("t6_post_rv", 64'(rd_valid), 64'd0);
        end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick($urandom_range(0, 9) < 3, $urandom_range(0, DEPTH - 1), WIDTH'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1),
                 $urandom_range(0, 9) < 3, $urandom_range(0, DEPTH - 1),
                 $urandom_range(0, 19) == 0);
        end

        chk_en = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
